// File: rtl/inpr_uart_rx_team1.sv
// Serial 8N1 receive front end for the INPR input register.
// Deserialises an LSB-first asynchronous line, strobes LD_INPR for one clock per
// good byte, and drops bytes that arrive while FGI still flags an unread byte.
module inpr_uart_rx_team1 #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       RST_n,
    input  logic       rx,
    input  logic       FGI,
    input  logic       clr_err,
    output logic [7:0] out_data,
    output logic       LD_INPR,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_out_data;
    logic             r_ld;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Receive FSM with bit timing, shift register and registered outputs.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_out_data  <= 8'h00;
            r_ld        <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_ld <= 1'b0;
            // Clear first so that an error set later in this block takes priority.
            if (clr_err) begin
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    r_idx <= 3'd0;
                    if (!w_rx_s) begin
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    // Half-bit check rejects glitches and aligns later samples to mid-bit.
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        r_idx   <= 3'd0;
                        r_state <= w_rx_s ? StIdle : StData;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                StData: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        if (r_idx == 3'd7) begin
                            r_state <= StStop;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                StStop: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                        if (!w_rx_s) begin
                            r_frame_err <= 1'b1;
                        end else if (FGI) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_out_data <= r_shift;
                            r_ld       <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign LD_INPR   = r_ld;
    assign busy      = (r_state != StIdle);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_inpr_uart_rx_team1.sv
// Directed bench for the INPR serial receiver: timing, overrun, framing,
// false start and mid-frame reset, with hand-computed expectations.
module tb_inpr_uart_rx_team1;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       RST_n;
    logic       rx;
    logic       FGI;
    logic       clr_err;
    logic [7:0] out_data;
    logic       LD_INPR;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         ld_count = 0;
    int         ld_cyc  [16];
    logic [7:0] ld_data [16];
    int         s0, s1, s2;

    inpr_uart_rx_team1 #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (8)
    ) u_dut (
        .clk      (clk),
        .RST_n    (RST_n),
        .rx       (rx),
        .FGI      (FGI),
        .clr_err  (clr_err),
        .out_data (out_data),
        .LD_INPR  (LD_INPR),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Count rising edges so load strobes can be timed against stimulus.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle in which LD_INPR is high, with the byte presented.
    always @(negedge clk) begin
        if (LD_INPR === 1'b1 && ld_count < 16) begin
            ld_cyc[ld_count]  <= cyc;
            ld_data[ld_count] <= out_data;
            ld_count          <= ld_count + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Leave the caller 1 time unit after the n-th following rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 10-bit frame; start_cyc is the edge just before the start bit falls.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int start_cyc);
        logic [9:0] frame;
        frame     = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    initial begin
        RST_n   = 1'b0;
        rx      = 1'b1;
        FGI     = 1'b0;
        clr_err = 1'b0;

        // Reset state
        idle(3);
        @(negedge clk);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_ld", 32'(LD_INPR), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        RST_n = 1'b1;
        idle(4);

        // Single good byte and its latency
        send_byte(8'hA5, 1'b1, s0);
        @(negedge clk);
        check("a5_ld_count", 32'(ld_count), 32'd1);
        check("a5_latency", 32'(ld_cyc[0] - s0), 32'd155);
        check("a5_ld_data", 32'(ld_data[0]), 32'hA5);
        check("a5_out_data", 32'(out_data), 32'hA5);
        check("a5_frame_err", 32'(frame_err), 32'd0);
        check("a5_overrun", 32'(overrun), 32'd0);
        check("a5_busy_idle", 32'(busy), 32'd0);
        idle(1);

        // Back-to-back frames, no idle time between them
        send_byte(8'h3C, 1'b1, s1);
        send_byte(8'h81, 1'b1, s2);
        @(negedge clk);
        check("b2b_ld_count", 32'(ld_count), 32'd3);
        check("b2b_latency1", 32'(ld_cyc[1] - s1), 32'd155);
        check("b2b_spacing", 32'(ld_cyc[2] - ld_cyc[1]), 32'd160);
        check("b2b_data1", 32'(ld_data[1]), 32'h3C);
        check("b2b_data2", 32'(ld_data[2]), 32'h81);
        idle(1);

        // Overrun while FGI is held high
        FGI = 1'b1;
        send_byte(8'h55, 1'b1, s0);
        idle(2);
        @(negedge clk);
        check("ovr_ld_count", 32'(ld_count), 32'd3);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_out_data", 32'(out_data), 32'h81);
        check("ovr_frame_err", 32'(frame_err), 32'd0);
        idle(1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        @(negedge clk);
        check("ovr_cleared", 32'(overrun), 32'd0);
        idle(1);

        // clr_err coincident with the overrun decision edge: set wins
        fork
            send_byte(8'h55, 1'b1, s0);
            begin
                idle(154);
                clr_err = 1'b1;
                idle(1);
                clr_err = 1'b0;
            end
        join
        @(negedge clk);
        check("ovr_set_wins", 32'(overrun), 32'd1);
        check("ovr2_ld_count", 32'(ld_count), 32'd3);
        FGI     = 1'b0;
        idle(1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        @(negedge clk);
        check("ovr2_cleared", 32'(overrun), 32'd0);
        idle(1);

        // Framing error, then a good byte with the sticky flag still set
        send_byte(8'h0F, 1'b0, s0);
        idle(32);
        @(negedge clk);
        check("fe_flag", 32'(frame_err), 32'd1);
        check("fe_ld_count", 32'(ld_count), 32'd3);
        check("fe_overrun", 32'(overrun), 32'd0);
        check("fe_busy", 32'(busy), 32'd0);
        check("fe_out_data", 32'(out_data), 32'h81);
        idle(1);
        send_byte(8'h42, 1'b1, s0);
        @(negedge clk);
        check("fe_next_ld_count", 32'(ld_count), 32'd4);
        check("fe_next_data", 32'(ld_data[3]), 32'h42);
        check("fe_next_latency", 32'(ld_cyc[3] - s0), 32'd155);
        check("fe_sticky", 32'(frame_err), 32'd1);
        idle(1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        @(negedge clk);
        check("fe_cleared", 32'(frame_err), 32'd0);
        idle(1);

        // False start: 5-clock low glitch
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        @(negedge clk);
        check("fs_busy_high", 32'(busy), 32'd1);
        idle(20);
        @(negedge clk);
        check("fs_busy_low", 32'(busy), 32'd0);
        check("fs_frame_err", 32'(frame_err), 32'd0);
        check("fs_overrun", 32'(overrun), 32'd0);
        check("fs_ld_count", 32'(ld_count), 32'd4);
        idle(1);

        // Reset during data bit 4 of 0xFF
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(72);
        check("mr_busy_before", 32'(busy), 32'd1);
        RST_n = 1'b0;
        #2;
        check("mr_out_data", 32'(out_data), 32'h00);
        check("mr_ld", 32'(LD_INPR), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_frame_err", 32'(frame_err), 32'd0);
        check("mr_overrun", 32'(overrun), 32'd0);
        idle(3);
        RST_n = 1'b1;
        idle(120);
        @(negedge clk);
        check("mr_no_ld", 32'(ld_count), 32'd4);
        check("mr_busy_after", 32'(busy), 32'd0);
        idle(1);
        send_byte(8'h12, 1'b1, s0);
        @(negedge clk);
        check("mr_next_ld_count", 32'(ld_count), 32'd5);
        check("mr_next_data", 32'(ld_data[4]), 32'h12);
        check("mr_next_latency", 32'(ld_cyc[4] - s0), 32'd155);
        check("mr_next_out", 32'(out_data), 32'h12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inpr_uart_rx_team1.md
Name: inpr_uart_rx_team1

Overview:
- Serial receive front end that feeds the INPR input register.
- Deserialises an asynchronous 8N1 line (LSB first) into a byte.
- Presents the byte on out_data and pulses LD_INPR for exactly one clock.
- Honours the downstream FGI flag: a byte that completes while FGI=1 is dropped and flagged as overrun.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be an even value of at least 4.
- CNT_W, 8: width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- RST_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- FGI  input  1  input flag from the INPR stage; 1 means the previous byte has not yet been read.
- out_data  output  8  received byte; connects to in_INPR.
- LD_INPR  output  1  one-cycle load strobe to the INPR stage.
- busy  output  1  high whenever the FSM is not in IDLE.
- frame_err  output  1  sticky; set when the stop bit is sampled low.
- overrun  output  1  sticky; set when a valid byte completes while FGI=1.
- clr_err  input  1  synchronous clear of frame_err and overrun.

Behaviour:
- Reset: while RST_n=0, all outputs are 0 and the FSM is in IDLE. Both synchroniser flops reset to 1 (line idle).
- Reset mid-frame aborts the frame immediately. No LD_INPR is produced for it.
- Input sync: rx passes through a 2-flop synchroniser before use. rx_s denotes the synchronised value.
- Bit timing: a counter cnt counts 0..CLKS_PER_BIT-1 within each state.
- FSM states:
  - IDLE: wait for rx_s=0, then enter START with cnt=0.
  - START: at cnt=CLKS_PER_BIT/2-1, sample rx_s.
    - If rx_s=1, this is a false start: return to IDLE with no flags changed.
    - If rx_s=0, enter DATA with cnt=0 and bit index=0. This aligns all later samples to mid-bit.
  - DATA: at cnt=CLKS_PER_BIT-1, shift rx_s into shift register bit [idx], LSB first.
    - After idx=7, enter STOP.
  - STOP: at cnt=CLKS_PER_BIT-1, sample rx_s.
    - rx_s=0: set frame_err; out_data and LD_INPR unchanged; go to IDLE.
    - rx_s=1 and FGI=1: set overrun; drop the byte; out_data unchanged; go to IDLE.
    - rx_s=1 and FGI=0: on the next edge, load out_data from the shift register and assert LD_INPR for exactly one clock; go to IDLE.
- out_data holds its value until the next successful byte.
- Latency: LD_INPR rises 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks after the falling start edge on rx.
- Back-to-back frames: IDLE accepts a new start edge on the cycle after leaving STOP. No idle time beyond the stop bit is required.
- Simultaneous events:
  - clr_err and a new error in the same cycle: the set wins, and the flag reads 1.
  - FGI is sampled only in the STOP decision cycle. FGI changes at other times have no effect.
- busy=1 in START, DATA and STOP; busy=0 in IDLE.
- The block never writes FGI. The INPR stage sets FGI on LD_INPR and clears it on read.

Test Plan:
- Reset, then send 0xA5 with 16 clocks/bit and FGI=0:
  - LD_INPR is high for 1 cycle, 2+8+144+1=155 clocks after the start edge.
  - out_data=0xA5; frame_err=0; overrun=0.
- Send 0x3C and 0x81 back-to-back with FGI=0:
  - Two LD_INPR pulses, exactly 160 clocks apart.
  - out_data=0x3C, then 0x81.
- Hold FGI=1 and send 0x55:
  - No LD_INPR; overrun=1; out_data keeps its prior value.
  - Pulse clr_err: overrun returns to 0.
- Send 0x0F with the stop bit driven low:
  - frame_err=1; no LD_INPR.
  - A following good 0x42 loads normally while frame_err stays 1.
- Drive rx low for 5 clocks, then high:
  - False start: FSM back in IDLE, busy drops, no flags set, no LD_INPR.
- Assert RST_n=0 during data bit 4 of 0xFF:
  - All outputs 0 asynchronously; no LD_INPR afterwards.
  - The next clean frame 0x12 is received correctly.
